// File: rtl/ccff_bitstream_loader.sv
// Streams configuration words MSB-first onto a ccff_head/ccff_tail chain,
// stopping after CHAIN_LEN bits and folding returning tail bits into a parity flag.
module ccff_bitstream_loader #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CHAIN_LEN  = 36
) (
  input  logic                  prog_clk,
  input  logic                  pReset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  ccff_head,
  output logic                  config_enable,
  input  logic                  ccff_tail,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic                  tail_parity
);

  localparam int unsigned BCW = $clog2(CHAIN_LEN + 1);
  localparam int unsigned WCW = $clog2(DATA_WIDTH + 1);
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(CHAIN_LEN - 1);
  localparam logic [WCW-1:0] WORD_LAST = WCW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_sreg;
  logic [BCW-1:0]        r_bit_cnt;
  logic [WCW-1:0]        r_word_cnt;
  logic                  r_aborted;
  logic                  r_parity;

  // Abort outranks both the LOAD handshake and the final shift.
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      r_state    <= S_IDLE;
      r_sreg     <= '0;
      r_bit_cnt  <= '0;
      r_word_cnt <= '0;
      r_aborted  <= 1'b0;
      r_parity   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state   <= S_LOAD;
            r_bit_cnt <= '0;
            r_parity  <= 1'b0;
            r_aborted <= 1'b0;
          end
        end
        S_LOAD: begin
          if (abort) begin
            r_state   <= S_IDLE;
            r_aborted <= 1'b1;
          end else if (s_valid) begin
            r_sreg     <= s_data;
            r_word_cnt <= '0;
            r_state    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (abort) begin
            r_state   <= S_IDLE;
            r_aborted <= 1'b1;
          end else begin
            r_sreg     <= {r_sreg[DATA_WIDTH-2:0], 1'b0};
            r_bit_cnt  <= r_bit_cnt + BCW'(1);
            r_word_cnt <= r_word_cnt + WCW'(1);
            r_parity   <= r_parity ^ ccff_tail;
            if (r_bit_cnt == BIT_LAST) begin
              r_state <= S_DONE;
            end else if (r_word_cnt == WORD_LAST) begin
              r_state <= S_LOAD;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode only registered state, never s_valid or start.
  assign s_ready       = (r_state == S_LOAD);
  assign config_enable = (r_state == S_SHIFT);
  assign ccff_head     = config_enable & r_sreg[DATA_WIDTH-1];
  assign busy          = (r_state == S_LOAD) || (r_state == S_SHIFT);
  assign done          = (r_state == S_DONE);
  assign aborted       = r_aborted;
  assign tail_parity   = r_parity;

endmodule
